// File: rtl/gift_pkg.sv
// Shared types, constants and pure functions for the GIFT-128 key schedule sequencer.
package gift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRECOMP,
        ISSUE,
        DONE
    } state_t;

    localparam int GIFT128_ROUNDS = 40;
    localparam int KEY_W          = 128;
    localparam int RK_W           = 64;
    localparam int RC_W           = 6;

    localparam logic [RC_W-1:0] RC_INIT = 6'h01;

    // Round key is {U, V} = {k5||k4, k1||k0}.
    localparam int RK_U_HI = 95;
    localparam int RK_U_LO = 64;
    localparam int RK_V_HI = 31;
    localparam int RK_V_LO = 0;

    function automatic logic [RC_W-1:0] lfsr_step(input logic [RC_W-1:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [RC_W-1:0] lfsr_unstep(input logic [RC_W-1:0] c);
        return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
    endfunction

    // k7..k0 <- (k1 >>> 2) || (k0 >>> 12) || k7..k2
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k);
        return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    endfunction

    function automatic logic [RK_W-1:0] round_key(input logic [KEY_W-1:0] k);
        return {k[RK_U_HI:RK_U_LO], k[RK_V_HI:RK_V_LO]};
    endfunction

endpackage

// File: rtl/gift_key_sched_ctrl_if.sv
// Round-key valid/ready channel from the key schedule to the round datapath.
interface gift_key_sched_ctrl_if
    import gift_pkg::*;
#(
    parameter int IDX_W = 6
);
    logic             rkValid;
    logic             rkReady;
    logic [RK_W-1:0]  roundKey;
    logic [RC_W-1:0]  roundConst;
    logic [IDX_W-1:0] roundIdx;

    modport master (output rkValid, roundKey, roundConst, roundIdx, input rkReady);
    modport slave  (input rkValid, roundKey, roundConst, roundIdx, output rkReady);
endinterface

// File: rtl/gift_key_sched_ctrl_inv_fun.sv
// Combinational inverse GIFT-128 key update; only compiled with GIFT_KEYSCH_INV_EN.
`ifdef GIFT_KEYSCH_INV_EN
module gift_key_inv_fun
    import gift_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_prev
);
    // k7..k2 <- k5..k0, k1 <- k7 <<< 2, k0 <- k6 <<< 12
    assign key_prev = {key[95:0], key[125:112], key[127:126], key[99:96], key[111:100]};
endmodule
`endif

// File: rtl/gift_key_sched_ctrl.sv
// GIFT-128 key schedule sequencer; reverse-order issue built when GIFT_KEYSCH_INV_EN is defined.
module gift_key_sched_ctrl
    import gift_pkg::*;
#(
    parameter int ROUNDS = GIFT128_ROUNDS,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_W-1:0]      keyIn,
    input  logic                  decrypt,
    gift_key_sched_ctrl_if.master rk,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] key, key_nxt;
    logic [RC_W-1:0]  rc, rc_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             hs;
    logic             last;

    assign hs = rk.rkValid && rk.rkReady;

`ifdef GIFT_KEYSCH_INV_EN
    logic             inv, inv_nxt;
    logic [KEY_W-1:0] key_prev;

    gift_key_inv_fun u_inv (
        .key      (key),
        .key_prev (key_prev)
    );
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        key_nxt   = key;
        rc_nxt    = rc;
        idx_nxt   = idx;
        last      = 1'b0;
`ifdef GIFT_KEYSCH_INV_EN
        inv_nxt   = inv;
`endif
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    key_nxt   = keyIn;
                    rc_nxt    = RC_INIT;
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
`ifdef GIFT_KEYSCH_INV_EN
                    inv_nxt   = decrypt;
                    if (decrypt) state_nxt = PRECOMP;
`endif
                end
            end
            PRECOMP: begin
`ifdef GIFT_KEYSCH_INV_EN
                // idx doubles as the step counter; it lands on the last round index.
                key_nxt = key_update(key);
                rc_nxt  = lfsr_step(rc);
                if (idx == IDX_W'(ROUNDS - 2)) begin
                    idx_nxt   = IDX_LAST;
                    state_nxt = ISSUE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
`else
                state_nxt = IDLE;
`endif
            end
            ISSUE: begin
                if (hs) begin
`ifdef GIFT_KEYSCH_INV_EN
                    if (inv) begin
                        key_nxt = key_prev;
                        rc_nxt  = lfsr_unstep(rc);
                        idx_nxt = idx - 1'b1;
                        last    = (idx == '0);
                    end else
`endif
                    begin
                        key_nxt = key_update(key);
                        rc_nxt  = lfsr_step(rc);
                        idx_nxt = idx + 1'b1;
                        last    = (idx == IDX_LAST);
                    end
                    if (last) begin
                        state_nxt = DONE;
                        key_nxt   = '0;
                        rc_nxt    = '0;
                        idx_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                key_nxt   = '0;
                rc_nxt    = '0;
                idx_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort beats any handshake in the same cycle and never produces done.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            key_nxt   = '0;
            rc_nxt    = '0;
            idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= IDLE;
            key   <= '0;
            rc    <= '0;
            idx   <= '0;
`ifdef GIFT_KEYSCH_INV_EN
            inv   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            key   <= key_nxt;
            rc    <= rc_nxt;
            idx   <= idx_nxt;
`ifdef GIFT_KEYSCH_INV_EN
            inv   <= inv_nxt;
`endif
        end
    end

    assign rk.rkValid    = (state == ISSUE);
    assign rk.roundKey   = rk.rkValid ? round_key(key) : '0;
    assign rk.roundConst = rk.rkValid ? rc : '0;
    assign rk.roundIdx   = rk.rkValid ? idx : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_gift_key_sched_ctrl.sv
// Scoreboard bench for gift_key_sched_ctrl; reverse-order expectations follow GIFT_KEYSCH_INV_EN.
module tb_gift_key_sched_ctrl;

    localparam int ROUNDS = 40;
    localparam int IDX_W  = 6;
`ifdef GIFT_KEYSCH_INV_EN
    localparam int DEC_LAT = ROUNDS;
    localparam bit DEC_REV = 1'b1;
`else
    localparam int DEC_LAT = 1;
    localparam bit DEC_REV = 1'b0;
`endif

    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY_ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         decrypt;
    logic [127:0] keyIn;
    logic         busy;
    logic         done;

    gift_key_sched_ctrl_if #(.IDX_W(IDX_W)) rk ();

    gift_key_sched_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .keyIn   (keyIn),
        .decrypt (decrypt),
        .rk      (rk),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [5:0]  rc;
        logic [63:0] key;
        bit          chk_key;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   hs_cnt   = 0;
    int   done_cnt = 0;

    // Hand-derived GIFT round constants for rounds 0..39.
    logic [5:0] rc_tab [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
        6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
        6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
        6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
        6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    // Hand-derived round keys 0..2 for KEY_SEQ.
    logic [63:0] rk_seq [3] = '{
        64'h04050607_0C0D0E0F,
        64'h00010203_08090A0B,
        64'h4303E0F0_04050607
    };

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq = 0: every round key equals ck; seq = 1: KEY_SEQ with rounds 0..2 known.
    task automatic push_run(input bit rev, input bit seq, input logic [63:0] ck);
        for (int n = 0; n < ROUNDS; n++) begin
            exp_t e;
            int   i;
            i     = rev ? ROUNDS - 1 - n : n;
            e.idx = i;
            e.rc  = rc_tab[i];
            if (seq) begin
                e.chk_key = (i < 3);
                e.key     = (i < 3) ? rk_seq[i] : 64'h0;
            end else begin
                e.chk_key = 1'b1;
                e.key     = ck;
            end
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [127:0] k, input bit dec);
        keyIn   = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        decrypt = 1'b0;
    endtask

    task automatic first_valid(input string name, input int exp_lat);
        int cnt;
        cnt = 1;
        while (!rk.rkValid && cnt < 200) begin
            tick();
            cnt++;
        end
        check(name, cnt, exp_lat);
    endtask

    task automatic run(input string name, input bit bp, input int inject_at);
        bit seen;
        bit injected;
        int hs0;
        int d0;
        seen     = 1'b0;
        injected = 1'b0;
        hs0      = hs_cnt;
        d0       = done_cnt;
        for (int c = 0; c < 400 && !seen; c++) begin
            rk.rkReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!injected && inject_at >= 0 && rk.rkValid && rk.roundIdx == inject_at) begin
                start    = 1'b1;
                keyIn    = KEY_ONES;
                injected = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_handshakes"}, hs_cnt - hs0, ROUNDS);
        check({name, "_sb_empty"}, sb.size(), 0);
        rk.rkReady = 1'b1;
        tick();
        check({name, "_busy_fall"}, busy, 1'b0);
        check({name, "_done_one_cycle"}, done, 1'b0);
        check({name, "_done_count"}, done_cnt - d0, 1);
        sb.delete();
    endtask

    // Scoreboard monitor: compares on the falling edge, pops on a real handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rk.rkValid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", rk.rkValid, 1'b0);
                end else begin
                    check("round_idx", rk.roundIdx, sb[0].idx);
                    check("round_const", rk.roundConst, sb[0].rc);
                    if (sb[0].chk_key) check("round_key", rk.roundKey, sb[0].key);
                    if (rk.rkReady && !abort) begin
                        void'(sb.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                check("idle_key_zero", rk.roundKey, 64'h0);
                check("idle_const_zero", rk.roundConst, 6'h0);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int d0;
        bit hit;

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        decrypt    = 1'b0;
        keyIn      = '0;
        rk.rkReady = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_valid", rk.rkValid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_key", rk.roundKey, 64'h0);
        check("rst_const", rk.roundConst, 6'h0);
        check("rst_idx", rk.roundIdx, 6'h0);

        // Zero key, always ready, ignored start (different key) at round 5.
        rk.rkReady = 1'b1;
        push_run(1'b0, 1'b0, 64'h0);
        do_start(128'h0, 1'b0);
        first_valid("zero_latency", 1);
        check("zero_busy", busy, 1'b1);
        run("zero", 1'b0, 5);

        // All-ones key, abort at round 17 together with rkReady.
        push_run(1'b0, 1'b0, {64{1'b1}});
        hs0 = hs_cnt;
        d0  = done_cnt;
        do_start(KEY_ONES, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (rk.rkValid && rk.roundIdx == 17) hit = 1'b1;
            else tick();
        end
        check("abort_reach_17", hit, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_handshakes", hs_cnt - hs0, 17);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", rk.rkValid, 1'b0);
        check("abort_key", rk.roundKey, 64'h0);
        check("abort_const", rk.roundConst, 6'h0);
        sb.delete();
        repeat (3) tick();
        check("abort_no_done", done_cnt - d0, 0);

        // Start and abort together in IDLE: abort wins.
        keyIn = KEY_SEQ;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 1'b0);
        tick();
        check("start_abort_valid", rk.rkValid, 1'b0);

        // Reset mid-run: back to idle, no done.
        push_run(1'b0, 1'b0, 64'h0);
        d0 = done_cnt;
        do_start(128'h0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", rk.rkValid, 1'b0);
        sb.delete();
        tick();
        check("midrst_no_done", done_cnt - d0, 0);

        // Structured key after abort/reset, random backpressure.
        push_run(1'b0, 1'b1, 64'h0);
        do_start(KEY_SEQ, 1'b0);
        first_valid("seq_latency", 1);
        run("seq_bp", 1'b1, -1);

        // Decrypt request: reverse order when the inverse feature is built, ignored otherwise.
        rk.rkReady = 1'b1;
        push_run(DEC_REV, 1'b1, 64'h0);
        do_start(KEY_SEQ, 1'b1);
        first_valid("dec_latency", DEC_LAT);
        run("dec", 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gift_key_sched_ctrl.md
Name: gift_key_sched_ctrl

Overview:
- Sequencer for the GIFT-128 key schedule. Holds the 128-bit key state, applies the key-update function once per consumed round, and presents the 64-bit round key and the 6-bit round constant to the round datapath.
- Handshake is valid/ready toward the round datapath. Start, abort and done go to/from the top-level cipher controller.

Parameters:
- ROUNDS, 40, number of round keys issued per run (GIFT-128 = 40).
- IDX_W, 6, width of roundIdx; must satisfy 2**IDX_W >= ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; keyIn and decrypt sampled when start && !busy.
- abort  in  1  cancel the current run.
- keyIn  in  128  master key; k7 is in [127:112], k0 is in [15:0].
- decrypt  in  1  1 = issue keys in reverse order (only with optional feature).
- rkReady  in  1  datapath consumes the current round key.
- rkValid  out  1  roundKey, roundConst and roundIdx are valid.
- roundKey  out  64  {U, V} = {key[95:64], key[31:0]}; forced to 0 when rkValid = 0.
- roundConst  out  6  current round constant; 0 when rkValid = 0.
- roundIdx  out  IDX_W  index of the current round (0-based).
- busy  out  1  run in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last key is consumed.

Behaviour:
- Reset: state IDLE; key, rc and idx registers = 0; all outputs 0.
- Forward update: k7..k0 <- (k1 >>> 2) || (k0 >>> 12) || k7..k2.
- LFSR step: (c5..c0) <- (c4, c3, c2, c1, c0, c5^c4^1).
- States:
  - IDLE: on start (encrypt), key <- keyIn, rc <- 0x01, idx <- 0, go to ISSUE. rkValid rises the next cycle (1-cycle latency).
  - ISSUE: rkValid = 1. On rkValid && rkReady: key <- update(key), rc <- step(rc), idx <- idx+1. If the handshake occurs at idx == ROUNDS-1, go to DONE instead.
  - DONE: done = 1 for exactly one cycle; key, rc and idx zeroized; go to IDLE.
- Without a handshake, outputs hold stable; rkValid never deasserts mid-run except via abort or rst.
- start while busy: ignored.
- abort (any non-IDLE state): go to IDLE next cycle, zeroize key/rc/idx, no done pulse. Abort has priority over a simultaneous handshake.
- start and abort together in IDLE: abort wins; the run does not start.
- rst mid-run: identical to reset; no done pulse.
- idx never wraps; the terminal compare is an exact match against ROUNDS-1.

Optional Feature:
- Macro GIFT_KEYSCH_INV_EN.
- Defined: start with decrypt = 1 enters PRECOMP. PRECOMP applies the forward update and LFSR step ROUNDS-1 times, one per cycle, with rkValid = 0; a counter tracks the steps.
- Then go to ISSUE with idx = ROUNDS-1. Each handshake applies the inverse update:
  - k7..k2 <- k5..k0
  - k1 <- (k7 <<< 2)
  - k0 <- (k6 <<< 12)
- Each handshake also applies the inverse LFSR, prev = {c0^c5^1, c5, c4, c3, c2, c1}, and decrements idx. Terminal condition is idx == 0, then DONE.
- First key latency in decrypt mode = ROUNDS cycles after start. abort during PRECOMP returns to IDLE.
- Undefined: decrypt is ignored, PRECOMP is not built, and no inverse logic is present.

Decomposition:
- Package gift_pkg:
  - state enum (IDLE, PRECOMP, ISSUE, DONE)
  - GIFT128_ROUNDS = 40
  - RC_INIT = 6'h01
  - functions lfsr_step / lfsr_unstep
  - round-key extraction slice positions
- Forward update: reuse the team's existing key-update function block (combinational).
- One new sub-module: gift_key_inv_fun, combinational 128->128 inverse update, built only under GIFT_KEYSCH_INV_EN.

Test Plan:
- Constant sequence: keyIn = 0, start, rkReady = 1 constantly -> rkValid the cycle after start. roundConst sequence is 01, 03, 07, 0F, 1F, 3E, 3D, 3B; roundKey = 0 throughout; done pulses once after 40 handshakes; busy falls with done.
- Key extraction: keyIn = 128'h000102030405060708090A0B0C0D0E0F -> round 0 roundKey = 64'h04050607_0C0D0E0F, round 1 = 64'h00010203_08090A0B.
- Backpressure: rkReady toggled randomly -> outputs stable while rkReady = 0; exactly 40 handshakes; idx 0..39 with no gaps.
- Abort: abort at round 17 together with rkReady = 1 -> IDLE next cycle, no done, roundKey/roundConst = 0; a new start then runs correctly from round 0.
- Start while busy: start with a different key at round 5 -> ignored; the sequence is unchanged.
- INV (macro on): same key, decrypt = 1 -> first rkValid 40 cycles after start; keys and constants equal the encrypt run in exact reverse order; idx 39 down to 0.
